// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared definitions for the core memory stage. Holds the
//             data/address width, the default bus timeout, the memory-stage
//             FSM state encoding and a counter-width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int C_XLEN            = 32;
    localparam int C_DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

    // Bits needed to hold values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_timer
//  Purpose  : Saturating transaction watchdog. Counts enabled cycles from 0
//             and flags expire while the count sits at LIMIT-1.
//  Ports    : clk    - clock, rising edge
//             reset  - asynchronous active-high reset
//             clear  - synchronous clear of the count
//             enable - count this cycle
//             expire - high in the enabled cycle whose count is LIMIT-1
//  Revision : 1.0 - initial release
// ============================================================================
module mem_timer
    import cpu_pkg::*;
#(
    parameter int LIMIT = C_DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int              C_CW   = cnt_width(LIMIT);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(LIMIT - 1);

    logic [C_CW-1:0] r_count;

    // Saturates at the last value so a transaction that slips past the
    // limit (e.g. grant on the final REQ cycle) still expires in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != C_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expire = enable && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Core memory stage. Turns a core load/store request into a
//             single bus transaction (request/grant, then read-data for
//             loads), stalls the core until it completes, and aborts with a
//             one-cycle err pulse if the bus does not respond in time.
//  Config   : MISALIGN_CHECK_EN - when defined, accesses with addr[1:0]!=0
//             skip the bus and finish with a one-cycle misalign pulse.
//             When undefined, misalign stays 0 and bus_addr[1:0] is 00.
//  Ports    : clk, reset             - clock / async active-high reset
//             rvalid, wvalid          - core load / store request
//             addr, wdata             - core byte address / store data
//             rdata_dm                - load data returned to the core
//             stall                   - freezes the core PC while high
//             err, misalign           - one-cycle status pulses (in DONE)
//             bus_req, bus_we         - bus request / write enable
//             bus_addr, bus_wdata     - bus address / write data
//             bus_gnt, bus_rvalid     - request accepted / read data valid
//             bus_rdata               - bus read data
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = C_DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rvalid,
    input  logic              wvalid,
    input  logic [C_XLEN-1:0] addr,
    input  logic [C_XLEN-1:0] wdata,
    output logic [C_XLEN-1:0] rdata_dm,
    output logic              stall,
    output logic              err,
    output logic              misalign,
    output logic              bus_req,
    output logic              bus_we,
    output logic [C_XLEN-1:0] bus_addr,
    output logic [C_XLEN-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [C_XLEN-1:0] bus_rdata
);

`ifdef MISALIGN_CHECK_EN
    localparam logic              C_MISALIGN_EN = 1'b1;
    localparam logic [C_XLEN-1:0] C_ADDR_MASK   = {C_XLEN{1'b1}};
`else
    localparam logic              C_MISALIGN_EN = 1'b0;
    localparam logic [C_XLEN-1:0] C_ADDR_MASK   = {{(C_XLEN-2){1'b1}}, 2'b00};
`endif

    mem_state_t        r_state;
    logic [C_XLEN-1:0] r_addr;
    logic [C_XLEN-1:0] r_wdata;
    logic              r_store;
    logic [C_XLEN-1:0] r_rdata;
    logic              r_bus_req;
    logic              r_bus_we;
    logic              r_err;
    logic              r_misalign;

    logic w_request;
    logic w_is_store;
    logic w_misaligned;
    logic w_tmr_clear;
    logic w_tmr_enable;
    logic w_expire;

    assign w_request    = rvalid | wvalid;
    // A simultaneous load and store request performs the load only.
    assign w_is_store   = wvalid & ~rvalid;
    // Constant 0 when the check is compiled out, so r_misalign never sets.
    assign w_misaligned = C_MISALIGN_EN && (addr[1:0] != 2'b00);

    // Counter is held at zero in IDLE, so it starts from 0 on IDLE->REQ.
    assign w_tmr_clear  = (r_state == ST_IDLE);
    assign w_tmr_enable = (r_state == ST_REQ) || (r_state == ST_WAIT);

    mem_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_tmr_clear),
        .enable (w_tmr_enable),
        .expire (w_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_store    <= 1'b0;
            r_rdata    <= '0;
            r_bus_req  <= 1'b0;
            r_bus_we   <= 1'b0;
            r_err      <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses shown only in DONE.
            r_err      <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_request) begin
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_store <= w_is_store;
                        if (w_misaligned) begin
                            r_state    <= ST_DONE;
                            r_misalign <= 1'b1;
                            r_rdata    <= '0;
                        end else begin
                            r_state   <= ST_REQ;
                            r_bus_req <= 1'b1;
                            r_bus_we  <= w_is_store;
                        end
                    end
                end
                ST_REQ: begin
                    // Read data arriving with (or before) the grant is not
                    // ours yet; only WAIT captures bus_rdata.
                    if (bus_gnt) begin
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_state   <= r_store ? ST_DONE : ST_WAIT;
                    end else if (w_expire) begin
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_state   <= ST_DONE;
                        r_err     <= 1'b1;
                        r_rdata   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (bus_rvalid) begin
                        r_rdata <= bus_rdata;
                        r_state <= ST_DONE;
                    end else if (w_expire) begin
                        r_state <= ST_DONE;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Core keeps its request up until it sees stall drop in DONE.
    assign stall     = w_request && (r_state != ST_DONE);
    assign rdata_dm  = r_rdata;
    assign err       = r_err;
    assign misalign  = r_misalign;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_addr & C_ADDR_MASK;
    assign bus_wdata = r_wdata;

endmodule
`default_nettype wire
